// File: rtl/im_refill_if.sv
// CPU-fetch / main-memory / cache-write signal bundle for the instruction-cache refill controller.
// master = refill controller side, slave = CPU, memory and cache side.
interface im_refill_if #(
    parameter int WORDS = 16,
    parameter int TAG_W = 25,
    parameter int BLK_W = 3
);
    logic                   cpuReq;
    logic [31:0]            cpuAddress;
    logic                   cacheHit;
    logic                   memReq;
    logic [31:0]            memAddr;
    logic                   memAck;
    logic [31:0]            memData;
    logic                   memWrite;
    logic                   set;
    logic [BLK_W-1:0]       blockNo;
    logic [32*WORDS-1:0]    line0;
    logic [TAG_W-1:0]       tag0;
    logic                   v0;
    logic                   stall;
    logic [15:0]            missCount;

    modport master (
        input  cpuReq, cpuAddress, cacheHit, memAck, memData,
        output memReq, memAddr, memWrite, set, blockNo, line0, tag0, v0, stall, missCount
    );

    modport slave (
        output cpuReq, cpuAddress, cacheHit, memAck, memData,
        input  memReq, memAddr, memWrite, set, blockNo, line0, tag0, v0, stall, missCount
    );
endinterface

// File: rtl/im_refill_ctrl.sv
// Instruction-cache miss handler: stalls the CPU, reads a line one word per ack, writes it to a victim block.
// Optional macro RAND_REPL_EN selects an 8-bit LFSR victim instead of per-set round-robin pointers.
module im_refill_ctrl #(
    parameter int WORDS = 16,
    parameter int TAG_W = 25,
    parameter int BLK_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    im_refill_if.master     bus
);
    localparam int CNT_W = $clog2(WORDS);
    localparam int OFF_W = $clog2(4 * WORDS);

    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, FILL = 2'd2, DONE = 2'd3} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [31:0]            base_q, base_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic                   setl_q, setl_d;
    logic [32*WORDS-1:0]    line_q, line_d;
    logic                   memreq_q, memreq_d;
    logic [31:0]            memaddr_q, memaddr_d;
    logic                   memwrite_q, memwrite_d;
    logic                   v0_q, v0_d;
    logic                   seto_q, seto_d;
    logic [TAG_W-1:0]       tago_q, tago_d;
    logic [BLK_W-1:0]       blk_q, blk_d;
    logic [15:0]            miss_q, miss_d;
    logic [BLK_W-1:0]       victim_s;
    logic                   miss_s;
    logic                   unused_addr_s;

`ifdef RAND_REPL_EN
    logic [7:0]             lfsr_q, lfsr_d;

    // Free-running x^8+x^6+x^5+x^4+1 Fibonacci LFSR; low bits pick the victim.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR register, seeded non-zero so it never locks up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign victim_s = lfsr_q[BLK_W-1:0];
`else
    logic [BLK_W-1:0]       vic0_q, vic0_d;
    logic [BLK_W-1:0]       vic1_q, vic1_d;

    // Per-set round-robin pointer advances once the written line has been committed.
    always_comb begin
        vic0_d = vic0_q;
        vic1_d = vic1_q;
        if (state_q == DONE) begin
            if (setl_q) begin
                vic1_d = vic1_q + {{(BLK_W-1){1'b0}}, 1'b1};
            end else begin
                vic0_d = vic0_q + {{(BLK_W-1){1'b0}}, 1'b1};
            end
        end else begin
            vic0_d = vic0_q;
        end
    end

    // Victim pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vic0_q <= {BLK_W{1'b0}};
            vic1_q <= {BLK_W{1'b0}};
        end else begin
            vic0_q <= vic0_d;
            vic1_q <= vic1_d;
        end
    end

    assign victim_s = setl_q ? vic1_q : vic0_q;
`endif

    assign miss_s        = bus.cpuReq & ~bus.cacheHit;
    assign unused_addr_s = ^bus.cpuAddress[OFF_W-1:0];

    // Next-state and datapath: latch the miss, gather words, then present one write strobe.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        tag_d      = tag_q;
        setl_d     = setl_q;
        line_d     = line_q;
        memreq_d   = 1'b0;
        memaddr_d  = memaddr_q;
        memwrite_d = 1'b0;
        v0_d       = 1'b0;
        seto_d     = seto_q;
        tago_d     = tago_q;
        blk_d      = blk_q;
        miss_d     = miss_q;
        case (state_q)
            IDLE: begin
                if (miss_s) begin
                    state_d   = FETCH;
                    base_d    = {bus.cpuAddress[31:OFF_W], {OFF_W{1'b0}}};
                    tag_d     = bus.cpuAddress[31:32-TAG_W];
                    setl_d    = bus.cpuAddress[OFF_W];
                    cnt_d     = {CNT_W{1'b0}};
                    memreq_d  = 1'b1;
                    memaddr_d = base_d;
                    miss_d    = (miss_q != 16'hFFFF) ? miss_q + 16'd1 : miss_q;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                memreq_d = 1'b1;
                if (bus.memAck) begin
                    line_d[32*cnt_q +: 32] = bus.memData;
                    if (cnt_q == CNT_W'(WORDS - 1)) begin
                        state_d    = FILL;
                        cnt_d      = {CNT_W{1'b0}};
                        memreq_d   = 1'b0;
                        memaddr_d  = base_q;
                        memwrite_d = 1'b1;
                        v0_d       = 1'b1;
                        seto_d     = setl_q;
                        tago_d     = tag_q;
                        blk_d      = victim_s;
                    end else begin
                        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        memaddr_d = base_q + {{(32-CNT_W-2){1'b0}}, cnt_d, 2'b00};
                    end
                end else begin
                    state_d = FETCH;
                end
            end
            FILL: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; reset discards any partial line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= {CNT_W{1'b0}};
            base_q     <= 32'd0;
            tag_q      <= {TAG_W{1'b0}};
            setl_q     <= 1'b0;
            line_q     <= {(32*WORDS){1'b0}};
            memreq_q   <= 1'b0;
            memaddr_q  <= 32'd0;
            memwrite_q <= 1'b0;
            v0_q       <= 1'b0;
            seto_q     <= 1'b0;
            tago_q     <= {TAG_W{1'b0}};
            blk_q      <= {BLK_W{1'b0}};
            miss_q     <= 16'd0;
        end else begin
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            tag_q      <= tag_d;
            setl_q     <= setl_d;
            line_q     <= line_d;
            memreq_q   <= memreq_d;
            memaddr_q  <= memaddr_d;
            memwrite_q <= memwrite_d;
            v0_q       <= v0_d;
            seto_q     <= seto_d;
            tago_q     <= tago_d;
            blk_q      <= blk_d;
            miss_q     <= miss_d;
        end
    end

    // stall must rise in the detect cycle, so its IDLE term is combinational.
    assign bus.stall     = reset & ((state_q != IDLE) | miss_s);
    assign bus.memReq    = memreq_q;
    assign bus.memAddr   = memaddr_q;
    assign bus.memWrite  = memwrite_q;
    assign bus.v0        = v0_q;
    assign bus.set       = seto_q;
    assign bus.tag0      = tago_q;
    assign bus.blockNo   = blk_q;
    assign bus.line0     = line_q;
    assign bus.missCount = miss_q;
endmodule
